// File: rtl/ocram_dual_master_arb.sv
// ============================================================================
// Module   : ocram_dual_master_arb
// Summary  : Two-master Avalon-MM arbiter in front of one single-port
//            on-chip RAM. Read data returns with a fixed one-cycle latency.
//            Macro OCRAM_ARB_RR_EN selects round-robin arbitration.
//            Without it, arbitration is fixed priority with m0 over m1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ocram_dual_master_arb #(
  parameter int                ADDR_W    = 13,
  parameter int                DATA_W    = 32,
  parameter int                BE_W      = 4,
  parameter int                NUM_WORDS = 5120,
  parameter logic [DATA_W-1:0] OOR_DATA  = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam logic [0:0]      S_HOLD      = 1'b0;
  localparam logic [0:0]      S_RUN       = 1'b1;
  localparam logic [ADDR_W:0] c_num_words = (ADDR_W+1)'(NUM_WORDS);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              w_run;
  logic              w_req0;
  logic              w_req1;
  logic              w_prio0;
  logic              w_gnt0;
  logic              w_gnt1;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_write;
  logic              w_in_range;
  logic              w_rd_accept;
  logic              r_pend_valid;
  logic              r_pend_owner;
  logic              r_pend_oor;
  logic [DATA_W-1:0] w_ret_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_HOLD;
    else          r_state <= w_state_nxt;
  end

  // HOLD lasts exactly one cycle after reset; RUN is terminal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HOLD:  w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    w_run = (r_state == S_RUN);
  end

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

`ifdef OCRAM_ARB_RR_EN
  logic r_last_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_last_grant <= 1'b1;
    else if (w_gnt0) r_last_grant <= 1'b0;
    else if (w_gnt1) r_last_grant <= 1'b1;
  end

  assign w_prio0 = r_last_grant;
`else
  assign w_prio0 = 1'b1;
`endif

  assign w_gnt0 = w_run & w_req0 & (~w_req1 | w_prio0);
  assign w_gnt1 = w_run & w_req1 & ~w_gnt0;

  assign w_sel_addr  = w_gnt1 ? m1_address : m0_address;
  assign w_sel_write = w_gnt1 ? m1_write   : m0_write;
  assign w_in_range  = ({1'b0, w_sel_addr} < c_num_words);
  // A granted master with write low must be reading; write wins when both are set.
  assign w_rd_accept = (w_gnt0 | w_gnt1) & ~w_sel_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_owner <= 1'b0;
      r_pend_oor   <= 1'b0;
    end else begin
      r_pend_valid <= w_rd_accept;
      r_pend_owner <= w_gnt1;
      r_pend_oor   <= ~w_in_range;
    end
  end

  assign w_ret_data = r_pend_oor ? OOR_DATA : ram_readdata;

  always_comb begin
    m0_waitrequest   = ~w_run | (w_req0 & ~w_gnt0);
    m1_waitrequest   = ~w_run | (w_req1 & ~w_gnt1);
    ram_address      = '0;
    ram_byteenable   = '0;
    ram_writedata    = '0;
    ram_chipselect   = 1'b0;
    ram_write        = 1'b0;
    ram_clken        = 1'b1;
    m0_readdatavalid = r_pend_valid & ~r_pend_owner;
    m1_readdatavalid = r_pend_valid &  r_pend_owner;
    m0_readdata      = m0_readdatavalid ? w_ret_data : '0;
    m1_readdata      = m1_readdatavalid ? w_ret_data : '0;
    if (w_gnt0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
    end else if (w_gnt1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
    end
    if (w_gnt0 | w_gnt1) begin
      ram_chipselect = w_in_range;
      ram_write      = w_sel_write;
    end
  end

endmodule

`default_nettype wire
